b1b2_cmd_driver: RTL and testbench
==================================

Name: b1b2_cmd_driver

Overview:
- Command-side driver for the two-input (B1/B2) flip-flop. Accepts set/clear/toggle/nop commands over a valid/ready handshake and turns each into a timed B1/B2 pulse followed by a settle gap.
- Keeps a model of the expected Q, samples the flip-flop's Q after each command and flags mismatches.
- Sits between the control logic (or a bench) and the flip-flop, whose B1/B2 inputs it drives and whose Q it reads back.

Parameters:
- PULSE_CYCLES, 2, clock cycles B1/B2 stay asserted per command; legal range 1..255.
- GAP_CYCLES, 1, clock cycles with B1=B2=0 after the pulse, before Q is checked; legal range 1..255.
- INIT_Q, 0, expected-Q model value after reset.
- SKIP_REDUNDANT, 1, when 1, a SET with q_exp=1 or a CLEAR with q_exp=0 issues no pulse.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_op  input  2  command: 00 NOP, 01 CLEAR (B1=0,B2=1), 10 SET (B1=1,B2=0), 11 TOGGLE (B1=1,B2=1).
- cmd_ready  output  1  driver can accept a command.
- q_fb  input  1  Q from the flip-flop.
- B1  output  1  flip-flop input 1, registered.
- B2  output  1  flip-flop input 2, registered.
- done  output  1  one-cycle pulse when a command completes.
- mismatch  output  1  valid with done: 1 when q_fb != q_exp at check.
- q_exp  output  1  expected-Q model.
- err_count  output  8  saturating count of mismatches.

Behaviour:
- Reset values:
  - state IDLE, B1=0, B2=0, done=0, mismatch=0.
  - cmd_ready=1 (combinational, from state==IDLE).
  - q_exp=INIT_Q, err_count=0, counters 0.
- States: IDLE, DRIVE, GAP, CHECK.
- Handshake:
  - Accept occurs on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_op is latched at that edge.
  - cmd_ready=1 only in IDLE. cmd_valid held while cmd_ready=0 is ignored and not lost; the command is accepted when the driver returns to IDLE.
- IDLE -> DRIVE on accept of SET, CLEAR or TOGGLE.
  - Exception: with SKIP_REDUNDANT=1, a redundant SET/CLEAR goes to CHECK instead.
  - NOP also goes to CHECK, with no pulse.
- DRIVE:
  - B1/B2 take the op pattern on the cycle after accept and hold it for exactly PULSE_CYCLES cycles.
  - Then go to GAP; B1=B2=0 on the next cycle.
- GAP: B1=B2=0 for exactly GAP_CYCLES cycles, then go to CHECK.
- CHECK (one cycle):
  - done=1.
  - q_exp updates at entry: SET->1, CLEAR->0, TOGGLE->~q_exp, NOP/skip->unchanged.
  - mismatch=(q_fb != new q_exp), registered in the same cycle as done.
  - On mismatch, err_count increments and saturates at 255.
  - Then go to IDLE.
- Latency from accept edge to done:
  - Pulsed command: done is high PULSE_CYCLES+GAP_CYCLES+1 cycles after the accept edge.
  - NOP or skipped command: done is high 1 cycle after the accept edge.
  - cmd_ready returns on the cycle after done.
- Idle outputs: B1=B2=0 whenever not in DRIVE; done=0 outside CHECK; mismatch is cleared when done falls.
- Illegal encodings: not possible (2-bit op is fully decoded).
- Async reset mid-operation:
  - B1/B2 drop to 0 immediately, with no clock needed.
  - The in-flight command is discarded and q_exp returns to INIT_Q.
  - No done pulse is produced for the aborted command.
- Simultaneous events: accept in IDLE cannot coincide with done, since done occurs in CHECK. No back-to-back accept: minimum command spacing is 2 cycles (NOP/skip) or PULSE_CYCLES+GAP_CYCLES+2 cycles (pulsed).

Test Plan:
- Reset, then SET with q_fb tied to the model's expected value (default params) -> B1=1,B2=0 for 2 cycles starting 1 cycle after accept; gap 1 cycle; done at accept+4; q_exp=1, mismatch=0, cmd_ready back at accept+5.
- CLEAR then TOGGLE, with q_fb driven by a behavioural flip-flop -> CLEAR gives B2 pulse, q_exp=0; TOGGLE gives B1=B2=1 for 2 cycles, q_exp=1; err_count stays 0.
- SET issued while q_exp=1 with SKIP_REDUNDANT=1 -> no B1/B2 activity; done at accept+1; q_exp stays 1. Same with SKIP_REDUNDANT=0 -> full pulse issued.
- q_fb held at 0 while issuing 300 SET/CLEAR alternations -> mismatch=1 on every SET done; err_count saturates at 255 and does not wrap.
- cmd_valid held high continuously with a changing op sequence (PULSE_CYCLES=3, GAP_CYCLES=2) -> each op accepted only when cmd_ready=1; spacing between accepts is 7 cycles; no op is skipped.
- rst asserted mid-DRIVE (between clock edges) -> B1/B2 drop to 0 before the next edge; no done pulse; q_exp=INIT_Q; cmd_ready=1; after release, the next command runs normally.

Source files
------------

// File: rtl/b1b2_cmd_driver.sv
// ---------------------------------------------------------------------------
// b1b2_cmd_driver
//
// Command-side driver for a two-input (B1/B2) flip-flop. Each accepted
// command becomes a timed B1/B2 pulse, then a settle gap, then a one-cycle
// check of the flip-flop's Q against an internal expected-Q model.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_op     00 NOP, 01 CLEAR (B1=0,B2=1), 10 SET (B1=1,B2=0),
//              11 TOGGLE (B1=1,B2=1)
//   cmd_ready  driver can accept a command (combinational, high in IDLE)
//   q_fb       Q read back from the flip-flop
//   B1, B2     registered flip-flop drive
//   done       one-cycle pulse when a command completes
//   mismatch   valid with done: q_fb differed from the updated q_exp
//   q_exp      expected-Q model
//   err_count  saturating count of mismatches
// ---------------------------------------------------------------------------
module b1b2_cmd_driver #(
  parameter int unsigned PULSE_CYCLES   = 2,    // 1..255
  parameter int unsigned GAP_CYCLES     = 1,    // 1..255
  parameter bit          INIT_Q         = 1'b0,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       q_fb,
  output logic       B1,
  output logic       B2,
  output logic       done,
  output logic       mismatch,
  output logic       q_exp,
  output logic [7:0] err_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] op_q;
  logic [7:0] cnt;

  logic accept;
  logic no_pulse;
  logic chk_entry;
  logic q_chk;

  // Expected Q after applying op to the current model value.
  function automatic logic next_q(input logic [1:0] op, input logic q);
    case (op)
      OP_CLEAR:  return 1'b0;
      OP_SET:    return 1'b1;
      OP_TOGGLE: return ~q;
      default:   return q;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    accept    = 1'b0;
    no_pulse  = 1'b0;
    chk_entry = 1'b0;
    q_chk     = q_exp;

    accept   = cmd_valid && cmd_ready;
    // A SET onto an already-set Q (or CLEAR onto cleared Q) can be skipped.
    no_pulse = (cmd_op == OP_NOP) ||
               (SKIP_REDUNDANT && (((cmd_op == OP_SET)   &&  q_exp) ||
                                   ((cmd_op == OP_CLEAR) && !q_exp)));

    // CHECK is entered straight from IDLE for NOP/skip, or at the end of GAP.
    if (state == IDLE) begin
      chk_entry = accept && no_pulse;
      q_chk     = next_q(cmd_op, q_exp);
    end else if (state == GAP) begin
      chk_entry = (cnt == 8'd0);
      q_chk     = next_q(op_q, q_exp);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      cnt       <= 8'd0;
      B1        <= 1'b0;
      B2        <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      q_exp     <= INIT_Q;
      err_count <= 8'd0;
    end else begin
      // done/mismatch are only ever high for the single CHECK cycle.
      done     <= chk_entry;
      mismatch <= chk_entry && (q_fb != q_chk);

      if (chk_entry) begin
        q_exp <= q_chk;
        if ((q_fb != q_chk) && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            if (no_pulse) begin
              state <= CHECK;
            end else begin
              state <= DRIVE;
              B1    <= cmd_op[1];
              B2    <= cmd_op[0];
              cnt   <= PULSE_LAST;
            end
          end
        end
        DRIVE: begin
          if (cnt == 8'd0) begin
            state <= GAP;
            B1    <= 1'b0;
            B2    <= 1'b0;
            cnt   <= GAP_LAST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_b1b2_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_b1b2_cmd_driver
//
// Directed bench for b1b2_cmd_driver. Instance u_a uses default parameters
// (PULSE=2, GAP=1, SKIP_REDUNDANT=1); instance u_b uses PULSE=3, GAP=2,
// SKIP_REDUNDANT=0. Each instance reads Q from a behavioural B1/B2
// flip-flop that acts on the first cycle of each pulse.
// ---------------------------------------------------------------------------
module tb_b1b2_cmd_driver;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Instance A signals
  logic       valid_a = 1'b0;
  logic [1:0] op_a    = OP_NOP;
  logic       ready_a, b1_a, b2_a, done_a, mm_a, qexp_a;
  logic [7:0] err_a;
  logic       ffq_a, hold0_a = 1'b0;
  logic [1:0] prev_a;
  logic       qfb_a;

  // Instance B signals
  logic       valid_b = 1'b0;
  logic [1:0] op_b    = OP_NOP;
  logic       ready_b, b1_b, b2_b, done_b, mm_b, qexp_b;
  logic [7:0] err_b;
  logic       ffq_b;
  logic [1:0] prev_b;

  assign qfb_a = hold0_a ? 1'b0 : ffq_a;

  b1b2_cmd_driver u_a (
    .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_op(op_a),
    .cmd_ready(ready_a), .q_fb(qfb_a), .B1(b1_a), .B2(b2_a),
    .done(done_a), .mismatch(mm_a), .q_exp(qexp_a), .err_count(err_a)
  );

  b1b2_cmd_driver #(
    .PULSE_CYCLES(3), .GAP_CYCLES(2), .INIT_Q(1'b0), .SKIP_REDUNDANT(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_op(op_b),
    .cmd_ready(ready_b), .q_fb(ffq_b), .B1(b1_b), .B2(b2_b),
    .done(done_b), .mismatch(mm_b), .q_exp(qexp_b), .err_count(err_b)
  );

  // Behavioural flip-flops: act once, on the first cycle a pattern appears.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ffq_a <= 1'b0; prev_a <= 2'b00;
    end else begin
      prev_a <= {b1_a, b2_a};
      if (prev_a == 2'b00) begin
        case ({b1_a, b2_a})
          2'b10:   ffq_a <= 1'b1;
          2'b01:   ffq_a <= 1'b0;
          2'b11:   ffq_a <= ~ffq_a;
          default: ffq_a <= ffq_a;
        endcase
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ffq_b <= 1'b0; prev_b <= 2'b00;
    end else begin
      prev_b <= {b1_b, b2_b};
      if (prev_b == 2'b00) begin
        case ({b1_b, b2_b})
          2'b10:   ffq_b <= 1'b1;
          2'b01:   ffq_b <= 1'b0;
          2'b11:   ffq_b <= ~ffq_b;
          default: ffq_b <= ffq_b;
        endcase
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on u_a and wait for done. Returns the B1/B2 pattern
  // seen on the cycle after accept, the accept-to-done latency in cycles,
  // and mismatch/q_exp as seen with done.
  task automatic run_a(input logic [1:0] op, output logic [1:0] b_first,
                       output int lat, output logic mm, output logic qx);
    valid_a = 1'b1;
    op_a    = op;
    tick();
    valid_a = 1'b0;
    b_first = {b1_a, b2_a};
    lat     = 1;
    while (!done_a && lat < 12) begin
      tick();
      lat++;
    end
    mm = mm_a;
    qx = qexp_a;
    tick();
  endtask

  logic [1:0] bf;
  int         lat;
  logic       mm, qx;
  int         n;
  int         acc[4];
  logic [1:0] seq[4];
  int         set_bad;
  int         clr_bad;

  initial begin
    seq[0] = OP_SET; seq[1] = OP_SET; seq[2] = OP_CLEAR; seq[3] = OP_TOGGLE;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_ready", ready_a, 1'b1);
    check("rst_b1b2", {b1_a, b2_a}, 2'b00);
    check("rst_done", done_a, 1'b0);
    check("rst_mismatch", mm_a, 1'b0);
    check("rst_qexp", qexp_a, 1'b0);
    check("rst_err", err_a, 8'd0);
    rst = 1'b0;
    tick();

    // ---------------- SET, detailed timing ----------------
    valid_a = 1'b1; op_a = OP_SET;
    tick();                                  // accept edge
    valid_a = 1'b0;
    check("set_c1_b1b2", {b1_a, b2_a}, 2'b10);
    check("set_c1_ready", ready_a, 1'b0);
    tick();
    check("set_c2_b1b2", {b1_a, b2_a}, 2'b10);
    check("set_c2_done", done_a, 1'b0);
    tick();
    check("set_gap_b1b2", {b1_a, b2_a}, 2'b00);
    check("set_gap_done", done_a, 1'b0);
    tick();
    check("set_done", done_a, 1'b1);
    check("set_qexp", qexp_a, 1'b1);
    check("set_mismatch", mm_a, 1'b0);
    check("set_chk_ready", ready_a, 1'b0);
    tick();
    check("set_ready_back", ready_a, 1'b1);
    check("set_done_fall", done_a, 1'b0);
    check("set_mm_fall", mm_a, 1'b0);

    // ---------------- CLEAR then TOGGLE ----------------
    run_a(OP_CLEAR, bf, lat, mm, qx);
    check("clr_pattern", bf, 2'b01);
    check("clr_latency", lat, 4);
    check("clr_qexp", qx, 1'b0);
    check("clr_mm", mm, 1'b0);
    run_a(OP_TOGGLE, bf, lat, mm, qx);
    check("tog_pattern", bf, 2'b11);
    check("tog_latency", lat, 4);
    check("tog_qexp", qx, 1'b1);
    check("tog_mm", mm, 1'b0);
    check("tog_err", err_a, 8'd0);

    // ---------------- redundant SET skipped (q_exp=1) ----------------
    run_a(OP_SET, bf, lat, mm, qx);
    check("skip_pattern", bf, 2'b00);
    check("skip_latency", lat, 1);
    check("skip_qexp", qx, 1'b1);
    check("skip_mm", mm, 1'b0);
    check("skip_ready", ready_a, 1'b1);

    // NOP: no pulse, done one cycle after accept
    run_a(OP_NOP, bf, lat, mm, qx);
    check("nop_pattern", bf, 2'b00);
    check("nop_latency", lat, 1);
    check("nop_qexp", qx, 1'b1);

    // ---------------- held valid, no skip, PULSE=3 GAP=2 ----------------
    valid_b = 1'b1; op_b = seq[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!ready_b && n < 20) begin
        tick();
        n++;
      end
      check("hold_ready_wait", (n < 20), 1'b1);
      acc[i] = cyc;
      tick();                                // accept edge
      check("hold_pattern", {b1_b, b2_b}, {seq[i][1], seq[i][0]});
      check("hold_ready_low", ready_b, 1'b0);
      if (i < 3) op_b = seq[i+1];
      else       valid_b = 1'b0;
      if (i > 0) check("hold_spacing", acc[i] - acc[i-1], 7);
    end
    n = 0;
    while (!ready_b && n < 20) begin
      tick();
      n++;
    end
    check("hold_final_wait", (n < 20), 1'b1);
    check("hold_qexp", qexp_b, 1'b1);
    check("hold_err", err_b, 8'd0);

    // ---------------- err_count saturation ----------------
    hold0_a = 1'b1;
    set_bad = 0;
    clr_bad = 0;
    for (int i = 0; i < 300; i++) begin
      run_a(OP_CLEAR, bf, lat, mm, qx);
      if (mm !== 1'b0) clr_bad++;
      run_a(OP_SET, bf, lat, mm, qx);
      if (mm !== 1'b1) set_bad++;
    end
    check("sat_clear_mm_count", clr_bad, 0);
    check("sat_set_mm_count", set_bad, 0);
    check("sat_err", err_a, 8'd255);
    check("sat_qexp", qexp_a, 1'b1);
    hold0_a = 1'b0;

    // ---------------- async reset mid-DRIVE ----------------
    run_a(OP_CLEAR, bf, lat, mm, qx);        // re-sync model and flip-flop
    run_a(OP_SET, bf, lat, mm, qx);
    check("pre_rst_qexp", qx, 1'b1);
    valid_a = 1'b1; op_a = OP_TOGGLE;
    tick();
    valid_a = 1'b0;
    check("pre_rst_b1b2", {b1_a, b2_a}, 2'b11);
    #3;
    rst = 1'b1;
    #1;                                      // still before the next edge
    check("rst_mid_b1b2", {b1_a, b2_a}, 2'b00);
    check("rst_mid_ready", ready_a, 1'b1);
    check("rst_mid_qexp", qexp_a, 1'b0);
    check("rst_mid_err", err_a, 8'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_a !== 1'b0) n++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done_a !== 1'b0) n++;
    end
    check("rst_no_done", n, 0);
    run_a(OP_SET, bf, lat, mm, qx);
    check("post_rst_pattern", bf, 2'b10);
    check("post_rst_latency", lat, 4);
    check("post_rst_qexp", qx, 1'b1);
    check("post_rst_mm", mm, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
